flag_persistence_filter: RTL
============================

// Module: flag_persistence_filter
// PURPOSE
//  Downstream of the OR-reduction stage. Consumes its 1-bit per-cycle flag.
//  Raises a sticky alarm only after the flag has been high for K consecutive cycles.
//  Keeps a saturating count of qualified events, read out over a req/valid handshake.
//  Sits between per-channel flag reducers and the slow-control register block.
// PARAMETERS
//  K   3  consecutive high cycles needed to qualify an event; legal range K>=1
//  CW  8  width of the event counter; legal range CW>=2
// PORTS
//  clk        in   1   single clock domain
//  rstn       in   1   asynchronous, active-low reset
//  flag_i     in   1   per-cycle flag from the upstream OR-reduction stage
//  ack_i      in   1   alarm acknowledge; level-sampled each cycle
//  clear_i    in   1   synchronous clear of FSM, run counter and event counter
//  rd_req_i   in   1   readout request; one-cycle pulse
//  alarm_o    out  1   sticky qualified-event alarm
//  rd_valid_o out  1   one-cycle strobe; rd_data_o is valid while it is high
//  rd_data_o  out  CW  event-count snapshot
//  sat_o      out  1   high while the event counter is at all-ones
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, run=0, cnt=0, and every output is 0.
//   rd_data_o is held at 0 until the first read.
//  run width = $clog2(K+1). run saturates at K and never wraps.
//  FSM (registered; alarm_o = state==ALARM, a Moore output):
//   IDLE  : flag_i=1 -> ARM with run=1. If K==1, go directly to ALARM.
//   ARM   : flag_i=1 -> run=run+1; when run+1==K -> ALARM.
//           flag_i=0 -> IDLE with run=0. No partial credit is kept.
//   ALARM : on entry, cnt=cnt+1, saturating at 2^CW-1.
//           ack_i=1 & flag_i=1 -> WAIT_LOW.
//           ack_i=1 & flag_i=0 -> IDLE.
//           ack_i=0 -> stay. New flag activity is ignored.
//   WAIT_LOW: flag_i=0 -> IDLE with run=0. This stops a stuck-high flag from re-alarming.
//  Latency: flag_i rising at cycle 0, held high -> alarm_o high in cycle K.
//  clear_i has top priority over every event:
//   state=IDLE, run=0, cnt=0 next cycle, and alarm_o drops.
//   A rd_req_i in the same cycle still returns the pre-clear cnt.
//  Readout: rd_req_i=1 in cycle n ->
//   rd_valid_o=1 and rd_data_o=cnt(n) in cycle n+1;
//   cnt is cleared in the same edge.
//  Read coinciding with an ALARM entry increment:
//   the snapshot returns the old value and cnt becomes 1, so no event is lost.
//  Back-to-back rd_req_i is legal: each read returns the count accumulated since the previous read.
//  Illegal state encodings recover to IDLE on the next edge.
//   Required for SEU robustness under triplication.
//  sat_o is combinational: cnt=={CW{1'b1}}.
// STRUCTURE
//  Shared package fpf_pkg:
//   state enum {IDLE, ARM, ALARM, WAIT_LOW}, 2-bit encoding
//   function clog2 for sizing run
//  One natural sub-module: fpf_sat_counter, a CW-bit saturating counter with
//   inc, clr and read-and-clear; reused for per-channel hit counters.
//  All state/counter registers are triplicated with voters. The flag_i input fans in unvoted.
// TESTING
//  1 K=3; flag high for cycles 0..1, then low -> no alarm, run back to 0, cnt=0.
//  2 K=3; flag high for cycles 0..5, no ack -> alarm_o rises in cycle 3 and stays high, cnt=1;
//    ack in cycle 6 with flag low -> IDLE in cycle 7.
//  3 Stuck flag: hold flag high and ack the alarm -> WAIT_LOW, no second alarm, cnt stays 1;
//    drop flag and raise it again for 3 cycles -> second alarm, cnt=2.
//  4 CW=2; produce 5 qualified events -> cnt=3, sat_o=1; rd_req -> rd_data_o=3, then cnt=0, sat_o=0.
//  5 rd_req in the same cycle as an ALARM entry, with cnt=4 -> rd_data_o=4 and cnt=1 afterwards;
//    clear_i together with rd_req, cnt=2 -> rd_data_o=2, cnt=0, alarm_o=0.
//  6 rstn asserted mid-ARM, asynchronously between edges -> outputs 0 immediately;
//    after release, K fresh high cycles are needed for an alarm.

Source files
------------

// File: rtl/fpf_pkg.sv
// -----------------------------------------------------------------------------
// fpf_pkg
//   Shared types and helpers for the flag persistence filter.
//   state_t : FSM states, 2-bit encoding (IDLE, ARM, ALARM, WAIT_LOW)
//   clog2   : elaboration-time ceil(log2(v)), used to size the run counter
// -----------------------------------------------------------------------------
package fpf_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ARM      = 2'b01,
      ALARM    = 2'b10,
      WAIT_LOW = 2'b11
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/flag_persistence_filter_if.sv
// -----------------------------------------------------------------------------
// flag_persistence_filter_if
//   Event-count readout bus towards the slow-control register block.
//   rd_req_i   : one-cycle read request (master -> filter)
//   rd_valid_o : one-cycle strobe, rd_data_o valid while high (filter -> master)
//   rd_data_o  : CW-bit event-count snapshot (filter -> master)
//   sat_o      : event counter is at all-ones (filter -> master)
// -----------------------------------------------------------------------------
interface flag_persistence_filter_if #(
   parameter int unsigned CW = 8
) ();

   logic          rd_req_i;
   logic          rd_valid_o;
   logic [CW-1:0] rd_data_o;
   logic          sat_o;

   modport master (
      output rd_req_i,
      input  rd_valid_o,
      input  rd_data_o,
      input  sat_o
   );

   modport slave (
      input  rd_req_i,
      output rd_valid_o,
      output rd_data_o,
      output sat_o
   );

endinterface

// File: rtl/fpf_sat_counter.sv
// -----------------------------------------------------------------------------
// fpf_sat_counter
//   CW-bit saturating event counter with synchronous clear and read-and-clear.
//   All registers are triplicated and majority-voted.
//   clk        : clock
//   rstn       : asynchronous active-low reset
//   inc_i      : count one event (saturates at all-ones)
//   clr_i      : synchronous clear, highest priority for the count
//   rd_i       : snapshot the current count and clear it in the same edge
//   rd_valid_o : registered strobe one cycle after rd_i
//   rd_data_o  : snapshot, held until the next read (0 after reset)
//   sat_o      : combinational, count is all-ones
// -----------------------------------------------------------------------------
module fpf_sat_counter #(
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          inc_i,
   input  logic          clr_i,
   input  logic          rd_i,
   output logic          rd_valid_o,
   output logic [CW-1:0] rd_data_o,
   output logic          sat_o
);

   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] snap_q [3];
   logic [2:0]    vld_q;

   logic [CW-1:0] cnt_v, snap_v;
   logic          vld_v;
   logic [CW-1:0] cnt_d, snap_d;
   logic          vld_d;

   assign cnt_v  = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
   assign snap_v = (snap_q[0] & snap_q[1]) | (snap_q[0] & snap_q[2]) | (snap_q[1] & snap_q[2]);
   assign vld_v  = (vld_q[0] & vld_q[1]) | (vld_q[0] & vld_q[2]) | (vld_q[1] & vld_q[2]);

   assign sat_o      = &cnt_v;
   assign rd_valid_o = vld_v;
   assign rd_data_o  = snap_v;

   always_comb begin
      cnt_d  = cnt_v;
      snap_d = snap_v;
      vld_d  = rd_i;
      // Snapshot ignores clr_i so a read alongside a clear returns the old count.
      if (rd_i) snap_d = cnt_v;
      if (clr_i) begin
         cnt_d = '0;
      end else if (rd_i) begin
         // An event landing on the read edge starts the next interval at 1.
         cnt_d = inc_i ? CW'(1) : '0;
      end else if (inc_i && !sat_o) begin
         cnt_d = cnt_v + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < 3; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
         vld_q <= '0;
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            cnt_q[i]  <= cnt_d;
            snap_q[i] <= snap_d;
         end
         vld_q <= {3{vld_d}};
      end
   end

endmodule

// File: rtl/flag_persistence_filter.sv
// -----------------------------------------------------------------------------
// flag_persistence_filter
//   Raises a sticky alarm once flag_i has been high for K consecutive cycles
//   and counts qualified events in a saturating counter read over rd_bus.
//   State and run registers are triplicated and majority-voted; flag_i is not.
//   clk      : clock
//   rstn     : asynchronous active-low reset
//   flag_i   : per-cycle flag from the upstream OR-reduction stage
//   ack_i    : alarm acknowledge, level-sampled
//   clear_i  : synchronous clear of FSM, run counter and event counter
//   alarm_o  : sticky alarm (state == ALARM)
//   rd_bus   : readout bus (rd_req_i / rd_valid_o / rd_data_o / sat_o)
// -----------------------------------------------------------------------------
module flag_persistence_filter
   import fpf_pkg::*;
#(
   parameter int unsigned K  = 3,
   parameter int unsigned CW = 8
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        flag_i,
   input  logic                        ack_i,
   input  logic                        clear_i,
   output logic                        alarm_o,
   flag_persistence_filter_if.slave    rd_bus
);

   localparam int unsigned RW = clog2(K + 1);

   logic [1:0]    st_q [3];
   logic [RW-1:0] run_q [3];

   logic [1:0]    st_vote;
   state_t        st_v, st_d;
   logic [RW-1:0] run_v, run_d;
   logic [RW:0]   run_inc;
   logic          entry;

   assign st_vote = (st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]);
   assign st_v    = state_t'(st_vote);
   assign run_v   = (run_q[0] & run_q[1]) | (run_q[0] & run_q[2]) | (run_q[1] & run_q[2]);
   assign run_inc = {1'b0, run_v} + (RW+1)'(1);

   always_comb begin
      st_d  = st_v;
      run_d = run_v;
      case (st_v)
         IDLE: begin
            run_d = '0;
            if (flag_i) begin
               run_d = RW'(1);
               st_d  = (K == 1) ? ALARM : ARM;
            end
         end
         ARM: begin
            if (flag_i) begin
               run_d = run_inc[RW-1:0];
               if (run_inc == (RW+1)'(K)) st_d = ALARM;
            end else begin
               st_d  = IDLE;
               run_d = '0;
            end
         end
         ALARM: begin
            if (ack_i) begin
               if (flag_i) begin
                  st_d = WAIT_LOW;
               end else begin
                  st_d  = IDLE;
                  run_d = '0;
               end
            end
         end
         WAIT_LOW: begin
            if (!flag_i) begin
               st_d  = IDLE;
               run_d = '0;
            end
         end
         default: begin
            st_d  = IDLE;
            run_d = '0;
         end
      endcase
      if (clear_i) begin
         st_d  = IDLE;
         run_d = '0;
      end
   end

   // Counts transitions into ALARM only; a clear forces st_d to IDLE so it never counts.
   assign entry   = (st_d == ALARM) && (st_v != ALARM);
   assign alarm_o = (st_v == ALARM);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < 3; i++) begin
            st_q[i]  <= IDLE;
            run_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            st_q[i]  <= st_d;
            run_q[i] <= run_d;
         end
      end
   end

   fpf_sat_counter #(
      .CW (CW)
   ) u_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .inc_i      (entry),
      .clr_i      (clear_i),
      .rd_i       (rd_bus.rd_req_i),
      .rd_valid_o (rd_bus.rd_valid_o),
      .rd_data_o  (rd_bus.rd_data_o),
      .sat_o      (rd_bus.sat_o)
   );

endmodule
